// File: rtl/cache_arbiter_pkg.sv
// Shared types and line/address constants for the cache-to-memory arbiter
// and the cache blocks that sit above it.
package arb_types;

    localparam int LINE_W = 256;
    localparam int ADDR_W = 32;

    typedef enum logic [2:0] {
        IDLE,
        SERVE_I,
        SERVE_D,
        RESP_I,
        RESP_D
    } arb_state_t;

    typedef enum logic {
        OWNER_I,
        OWNER_D
    } arb_owner_t;

endpackage

// File: rtl/cache_arbiter_reg.sv
// Parameterised enabled register with synchronous active-low clear.
module cache_arbiter_reg #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    always_ff @(posedge clk) begin
        if (!rst) begin
            q <= '0;
        end else if (en) begin
            q <= d;
        end
    end

endmodule

// File: rtl/cache_arbiter.sv
// Grants the single memory port to the I-cache or D-cache one line transfer at a time.
// state    | meaning
// IDLE     | no transaction; arbitrate pending requests
// SERVE_I  | I-cache line read outstanding on memory
// SERVE_D  | D-cache read or write-back outstanding on memory
// RESP_I   | one-cycle completion pulse to the I-cache
// RESP_D   | one-cycle completion pulse to the D-cache
module cache_arbiter
    import arb_types::*;
#(
    parameter int ADDR_W = arb_types::ADDR_W,
    parameter int LINE_W = arb_types::LINE_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_read,
    input  logic [ADDR_W-1:0] i_addr,
    output logic [LINE_W-1:0] i_rdata,
    output logic              i_resp,
    input  logic              d_read,
    input  logic              d_write,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [LINE_W-1:0] d_wdata,
    output logic [LINE_W-1:0] d_rdata,
    output logic              d_resp,
    output logic              m_read,
    output logic              m_write,
    output logic [ADDR_W-1:0] m_addr,
    output logic [LINE_W-1:0] m_wdata,
    input  logic [LINE_W-1:0] m_rdata,
    input  logic              m_resp
);

    arb_state_t        state, state_nx;
    arb_owner_t        last_served;
    logic [ADDR_W-1:0] addr_q;
    logic [LINE_W-1:0] wdata_q;
    logic              rd_q, wr_q;
    logic              grant_i, grant_d;
    logic              d_req;

    assign d_req = d_read | d_write;

    always_comb begin
        state_nx = state;
        grant_i  = 1'b0;
        grant_d  = 1'b0;
        case (state)
            IDLE: begin
                // On a tie the requester that waited longest wins.
                if (i_read && d_req) begin
                    grant_i = (last_served == OWNER_D);
                    grant_d = (last_served == OWNER_I);
                end else begin
                    grant_i = i_read;
                    grant_d = d_req;
                end
                if (grant_i) state_nx = SERVE_I;
                else if (grant_d) state_nx = SERVE_D;
            end
            SERVE_I: if (m_resp) state_nx = RESP_I;
            SERVE_D: if (m_resp) state_nx = RESP_D;
            RESP_I:  state_nx = IDLE;
            RESP_D:  state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state       <= IDLE;
            last_served <= OWNER_D;
            addr_q      <= '0;
            wdata_q     <= '0;
            rd_q        <= 1'b0;
            wr_q        <= 1'b0;
        end else begin
            state <= state_nx;
            if (grant_i) begin
                last_served <= OWNER_I;
                addr_q      <= i_addr;
                rd_q        <= 1'b1;
                wr_q        <= 1'b0;
            end else if (grant_d) begin
                // A simultaneous read and write-back is carried out as the write.
                last_served <= OWNER_D;
                addr_q      <= d_addr;
                wdata_q     <= d_wdata;
                rd_q        <= d_read & ~d_write;
                wr_q        <= d_write;
            end
        end
    end

    assign m_read  = ((state == SERVE_I) || (state == SERVE_D)) && rd_q;
    assign m_write = (state == SERVE_D) && wr_q;
    assign m_addr  = addr_q;
    assign m_wdata = wdata_q;
    assign i_resp  = (state == RESP_I);
    assign d_resp  = (state == RESP_D);

    cache_arbiter_reg #(.W(LINE_W)) u_i_rdata (
        .clk (clk),
        .rst (rst),
        .en  ((state == SERVE_I) && m_resp),
        .d   (m_rdata),
        .q   (i_rdata)
    );

    cache_arbiter_reg #(.W(LINE_W)) u_d_rdata (
        .clk (clk),
        .rst (rst),
        .en  ((state == SERVE_D) && m_resp && rd_q),
        .d   (m_rdata),
        .q   (d_rdata)
    );

endmodule

// File: tb/tb_cache_arbiter.sv
// Directed bench for cache_arbiter: table of single transactions plus
// hand-written tie, address-stability and reset-abort sequences.
module tb_cache_arbiter;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         i_read = 1'b0;
    logic [31:0]  i_addr = '0;
    logic [255:0] i_rdata;
    logic         i_resp;
    logic         d_read = 1'b0;
    logic         d_write = 1'b0;
    logic [31:0]  d_addr = '0;
    logic [255:0] d_wdata = '0;
    logic [255:0] d_rdata;
    logic         d_resp;
    logic         m_read, m_write;
    logic [31:0]  m_addr;
    logic [255:0] m_wdata;
    logic [255:0] m_rdata = '0;
    logic         m_resp = 1'b0;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    cache_arbiter dut (
        .clk     (clk),
        .rst     (rst),
        .i_read  (i_read),
        .i_addr  (i_addr),
        .i_rdata (i_rdata),
        .i_resp  (i_resp),
        .d_read  (d_read),
        .d_write (d_write),
        .d_addr  (d_addr),
        .d_wdata (d_wdata),
        .d_rdata (d_rdata),
        .d_resp  (d_resp),
        .m_read  (m_read),
        .m_write (m_write),
        .m_addr  (m_addr),
        .m_wdata (m_wdata),
        .m_rdata (m_rdata),
        .m_resp  (m_resp)
    );

    typedef struct {
        bit           use_i;
        bit           rd;
        bit           wr;
        logic [31:0]  addr;
        logic [255:0] wdata;
        logic [255:0] mdata;
        int           k;
        bit           exp_r;
        bit           exp_w;
        logic [255:0] exp_i;
        logic [255:0] exp_d;
    } vec_t;

    vec_t vecs[5];

    function automatic logic [255:0] fill(input logic [31:0] w);
        return {8{w}};
    endfunction

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    task automatic run_vec(input vec_t v, input string tag);
        step();
        if (v.use_i) begin
            i_read = 1'b1;
            i_addr = v.addr;
        end else begin
            d_read  = v.rd;
            d_write = v.wr;
            d_addr  = v.addr;
            d_wdata = v.wdata;
        end
        mid();
        chk({tag, "_c0_mread"}, m_read, 0);
        chk({tag, "_c0_mwrite"}, m_write, 0);
        for (int c = 1; c <= v.k; c++) begin
            step();
            if (c == v.k) begin
                m_resp  = 1'b1;
                m_rdata = v.mdata;
            end
            mid();
            chk({tag, "_mread"}, m_read, v.exp_r);
            chk({tag, "_mwrite"}, m_write, v.exp_w);
            chk({tag, "_maddr"}, m_addr, v.addr);
            if (v.wr) chk({tag, "_mwdata"}, m_wdata, v.wdata);
            chk({tag, "_iresp_early"}, i_resp, 0);
            chk({tag, "_dresp_early"}, d_resp, 0);
        end
        step();
        m_resp  = 1'b0;
        m_rdata = fill(32'hBAD0_BAD0);
        mid();
        chk({tag, "_iresp"}, i_resp, v.use_i);
        chk({tag, "_dresp"}, d_resp, !v.use_i);
        chk({tag, "_resp_mread"}, m_read, 0);
        chk({tag, "_resp_mwrite"}, m_write, 0);
        chk({tag, "_irdata"}, i_rdata, v.exp_i);
        chk({tag, "_drdata"}, d_rdata, v.exp_d);
        step();
        i_read  = 1'b0;
        d_read  = 1'b0;
        d_write = 1'b0;
        mid();
        chk({tag, "_idle_iresp"}, i_resp, 0);
        chk({tag, "_idle_dresp"}, d_resp, 0);
        chk({tag, "_idle_mread"}, m_read, 0);
        chk({tag, "_idle_mwrite"}, m_write, 0);
    endtask

    task automatic do_reset();
        step();
        rst = 1'b0;
        step();
        step();
        rst = 1'b1;
    endtask

    // Both caches request together; exp_i_first says who the rule picks.
    task automatic tie_seq(input bit exp_i_first, input string tag);
        logic [31:0] a_first, a_second;
        a_first  = exp_i_first ? 32'h0000_0A00 : 32'h0000_0B00;
        a_second = exp_i_first ? 32'h0000_0B00 : 32'h0000_0A00;
        step();
        i_read = 1'b1; i_addr = 32'h0000_0A00;
        d_read = 1'b1; d_addr = 32'h0000_0B00;
        step();
        m_resp = 1'b1; m_rdata = fill(32'h1111_1111);
        mid();
        chk({tag, "_first_mread"}, m_read, 1);
        chk({tag, "_first_maddr"}, m_addr, a_first);
        step();
        m_resp = 1'b0;
        mid();
        chk({tag, "_first_iresp"}, i_resp, exp_i_first);
        chk({tag, "_first_dresp"}, d_resp, !exp_i_first);
        step();
        if (exp_i_first) i_read = 1'b0; else d_read = 1'b0;
        mid();
        chk({tag, "_dead_mread"}, m_read, 0);
        step();
        m_resp = 1'b1; m_rdata = fill(32'h2222_2222);
        mid();
        chk({tag, "_second_mread"}, m_read, 1);
        chk({tag, "_second_maddr"}, m_addr, a_second);
        step();
        m_resp = 1'b0;
        mid();
        chk({tag, "_second_iresp"}, i_resp, !exp_i_first);
        chk({tag, "_second_dresp"}, d_resp, exp_i_first);
        step();
        i_read = 1'b0;
        d_read = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, got timeout want finish");
        $fatal(1, "timeout");
    end

    initial begin
        vecs[0] = '{1'b1, 1'b1, 1'b0, 32'h0000_1000, '0, fill(32'hAAAA_AAAA), 3,
                    1'b1, 1'b0, fill(32'hAAAA_AAAA), '0};
        vecs[1] = '{1'b0, 1'b0, 1'b1, 32'h0000_2040, fill(32'h5555_5555), fill(32'h9999_9999), 2,
                    1'b0, 1'b1, fill(32'hAAAA_AAAA), '0};
        vecs[2] = '{1'b0, 1'b1, 1'b0, 32'h0000_3000, '0, fill(32'hDEAD_BEEF), 1,
                    1'b1, 1'b0, fill(32'hAAAA_AAAA), fill(32'hDEAD_BEEF)};
        vecs[3] = '{1'b0, 1'b1, 1'b1, 32'h0000_4000, fill(32'h0F0F_0F0F), fill(32'h7777_7777), 1,
                    1'b0, 1'b1, fill(32'hAAAA_AAAA), fill(32'hDEAD_BEEF)};
        vecs[4] = '{1'b1, 1'b1, 1'b0, 32'h0000_5000, '0, fill(32'hC3C3_C3C3), 1,
                    1'b1, 1'b0, fill(32'hC3C3_C3C3), fill(32'hDEAD_BEEF)};

        step();
        step();
        mid();
        chk("rst_mread", m_read, 0);
        chk("rst_mwrite", m_write, 0);
        chk("rst_maddr", m_addr, 0);
        chk("rst_mwdata", m_wdata, 0);
        chk("rst_iresp", i_resp, 0);
        chk("rst_dresp", d_resp, 0);
        chk("rst_irdata", i_rdata, 0);
        chk("rst_drdata", d_rdata, 0);
        rst = 1'b1;

        for (int n = 0; n < 5; n++) begin
            run_vec(vecs[n], $sformatf("vec%0d", n));
        end

        // Fresh reset puts last_served back to D, so the first tie goes to I.
        do_reset();
        tie_seq(1'b1, "tie_a");
        // An I-only transfer leaves I as last served, so the next tie goes to D.
        run_vec('{1'b1, 1'b1, 1'b0, 32'h0000_6000, '0, fill(32'h3333_3333), 1,
                  1'b1, 1'b0, fill(32'h3333_3333), fill(32'h2222_2222)}, "ionly");
        tie_seq(1'b0, "tie_b");

        step();
        d_read = 1'b1; d_addr = 32'h0000_0100;
        step();
        mid();
        chk("hold_c1_maddr", m_addr, 32'h0000_0100);
        step();
        d_addr = 32'h0000_0200;
        mid();
        chk("hold_c2_maddr", m_addr, 32'h0000_0100);
        step();
        m_resp = 1'b1; m_rdata = fill(32'h4444_4444);
        mid();
        chk("hold_c3_maddr", m_addr, 32'h0000_0100);
        chk("hold_c3_mread", m_read, 1);
        step();
        m_resp = 1'b0;
        mid();
        chk("hold_dresp", d_resp, 1);
        chk("hold_drdata", d_rdata, fill(32'h4444_4444));
        step();
        d_read = 1'b0;

        step();
        i_read = 1'b1; i_addr = 32'h0000_0700;
        step();
        mid();
        chk("abort_c1_mread", m_read, 1);
        step();
        rst = 1'b0;
        mid();
        chk("abort_c2_mread", m_read, 1);
        step();
        rst = 1'b1;
        i_read = 1'b0;
        mid();
        chk("abort_mread", m_read, 0);
        chk("abort_iresp", i_resp, 0);
        chk("abort_irdata", i_rdata, 0);
        chk("abort_drdata", d_rdata, 0);
        step();
        m_resp = 1'b1; m_rdata = fill(32'hFFFF_FFFF);
        mid();
        chk("late_mread", m_read, 0);
        step();
        m_resp = 1'b0;
        mid();
        chk("late_iresp", i_resp, 0);
        chk("late_dresp", d_resp, 0);
        chk("late_irdata", i_rdata, 0);
        chk("late_drdata", d_rdata, 0);
        chk("late_mread2", m_read, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
